// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_INSN, OWN_DATA} owner_e;
    localparam int STARVE_MAX_DEF = 4;
    localparam int IO_ADDR_BIT = 31;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-command bundle; slave side is the arbiter
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] m_addr;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        halt;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_read, m_write, m_be, m_wdata, halt
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_read, m_write, m_be, m_wdata, halt
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot winner {data, insn}; i_pri lets fetch win a contended cycle
module mem_arb_pick (
    input  logic       i_req,
    input  logic       d_req,
    input  logic       i_pri,
    output logic [1:0] gnt
);
    always_comb gnt = (i_req && (!d_req || i_pri)) ? 2'b01 : d_req ? 2'b10 : 2'b00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory sharing between fetch and load/store; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MLEN       = 13,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    logic [1:0]  gnt;
    logic        i_pri;
    logic        i_gnt;
    logic        d_gnt;
    logic        d_rd;
    logic        d_st;
    owner_e      rsp_owner_q, rsp_owner_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
    logic        rr_q, rr_d;
    always_comb begin
        i_pri = rr_q;
        rr_d  = (bus.i_req && bus.d_req && reset) ? d_gnt : rr_q;
    end
    always_ff @(posedge clk) rr_q <= !reset ? 1'b0 : rr_d;
`else
    logic [2:0]  starve_q, starve_d;
    always_comb begin
        i_pri    = starve_q == 3'(STARVE_MAX);
        starve_d = (bus.i_req && !i_gnt) ? (i_pri ? starve_q : starve_q + 3'd1) : 3'd0;
    end
    always_ff @(posedge clk) starve_q <= !reset ? 3'd0 : starve_d;
`endif

    mem_arb_pick u_pick (
        .i_req(bus.i_req),
        .d_req(bus.d_req),
        .i_pri(i_pri),
        .gnt  (gnt)
    );

    always_comb begin
        i_gnt        = reset && gnt[0];
        d_gnt        = reset && gnt[1];
        d_rd         = d_gnt && !bus.d_we;
        d_st         = d_gnt && bus.d_we;
        bus.i_gnt    = i_gnt;
        bus.d_gnt    = d_gnt;
        bus.m_addr   = i_gnt ? bus.i_addr : d_gnt ? bus.d_addr : 32'd0;
        bus.m_read   = i_gnt || d_rd;
        // I/O-region stores are accepted but never reach the array
        bus.m_write  = d_st && !bus.d_addr[IO_ADDR_BIT];
        bus.m_be     = d_st ? bus.d_be : 4'd0;
        bus.m_wdata  = d_st ? bus.d_wdata : 32'd0;
        bus.halt     = reset && ((bus.i_req && !i_gnt) || (bus.d_req && !d_gnt));
        rsp_owner_d  = i_gnt ? OWN_INSN : d_rd ? OWN_DATA : OWN_NONE;
        bus.i_rvalid = reset && rsp_owner_q == OWN_INSN;
        bus.d_rvalid = reset && rsp_owner_q == OWN_DATA;
        i_rdata_d    = bus.i_rvalid ? bus.m_rdata : i_rdata_q;
        d_rdata_d    = bus.d_rvalid ? bus.m_rdata : d_rdata_q;
        bus.i_rdata  = i_rdata_d;
        bus.d_rdata  = d_rdata_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_owner_q <= OWN_NONE;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    a_write_in_array: assert property (@(posedge clk) disable iff (!reset)
        bus.m_write |-> (bus.m_addr >> MLEN) == 32'd0);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a per-cycle reference model and literal spot checks
module tb_mem_arbiter;
    localparam int STARVE_MAX = 4;
    logic clk = 1'b0;
    logic reset;
    int tests = 0;
    int fails = 0;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] ram [2048];
    logic [31:0] ref_mem [2048];

    // memory device seen by the DUT
    always @(posedge clk) begin
        if (bus.m_write)
            for (int b = 0; b < 4; b++)
                if (bus.m_be[b]) ram[bus.m_addr[12:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
        if (bus.m_read) bus.m_rdata <= ram[bus.m_addr[12:2]];
    end

    int          losses = 0;
    int          rsp = 0;
    logic [31:0] rsp_data = '0;
    logic [31:0] last_i = '0, last_d = '0;
    logic        ins_win, dat_win, is_store, e_mread, e_mwrite, e_halt, e_iv, e_dv;
    logic [31:0] e_maddr, e_mwdata, e_ir, e_dr;
    logic [3:0]  e_mbe;

    always_comb begin
        ins_win  = reset && bus.i_req && (!bus.d_req || losses >= STARVE_MAX);
        dat_win  = reset && bus.d_req && !ins_win;
        is_store = dat_win && bus.d_we;
        e_maddr  = ins_win ? bus.i_addr : dat_win ? bus.d_addr : 32'd0;
        e_mread  = ins_win || (dat_win && !bus.d_we);
        e_mwrite = is_store && !bus.d_addr[31];
        e_mbe    = is_store ? bus.d_be : 4'd0;
        e_mwdata = is_store ? bus.d_wdata : 32'd0;
        e_halt   = reset && ((bus.i_req && !ins_win) || (bus.d_req && !dat_win));
        e_iv     = reset && rsp == 1;
        e_dv     = reset && rsp == 2;
        e_ir     = e_iv ? rsp_data : last_i;
        e_dr     = e_dv ? rsp_data : last_d;
    end

    always @(posedge clk) begin
        if (!reset) begin
            losses <= 0;
            rsp    <= 0;
            last_i <= '0;
            last_d <= '0;
        end else begin
            losses   <= (bus.i_req && !ins_win) ? ((losses < STARVE_MAX) ? losses + 1 : losses) : 0;
            rsp      <= ins_win ? 1 : (dat_win && !bus.d_we) ? 2 : 0;
            rsp_data <= ref_mem[e_maddr[12:2]];
            last_i   <= e_ir;
            last_d   <= e_dr;
            if (e_mwrite)
                for (int b = 0; b < 4; b++)
                    if (e_mbe[b]) ref_mem[e_maddr[12:2]][8*b +: 8] <= e_mwdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("i_gnt", 32'(bus.i_gnt), 32'(ins_win));
        chk("d_gnt", 32'(bus.d_gnt), 32'(dat_win));
        chk("m_addr", bus.m_addr, e_maddr);
        chk("m_read", 32'(bus.m_read), 32'(e_mread));
        chk("m_write", 32'(bus.m_write), 32'(e_mwrite));
        chk("m_be", 32'(bus.m_be), 32'(e_mbe));
        chk("m_wdata", bus.m_wdata, e_mwdata);
        chk("halt", 32'(bus.halt), 32'(e_halt));
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(e_iv));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
        chk("i_rdata", bus.i_rdata, e_ir);
        chk("d_rdata", bus.d_rdata, e_dr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) begin
            ram[a] = '0;
            ref_mem[a] = '0;
        end
        ram[32'h100 >> 2] = 32'h0000_0013;
        ref_mem[32'h100 >> 2] = 32'h0000_0013;
        bus.m_rdata = '0;
        reset = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h200; bus.d_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
            chk("rst_halt", 32'(bus.halt), 32'd0);
            chk("rst_mread", 32'(bus.m_read), 32'd0);
            chk("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        end
        tick();
        reset = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        bus.i_req = 1'b1;
        @(negedge clk);
        chk("lone_i_gnt", 32'(bus.i_gnt), 32'd1);
        chk("lone_m_addr", bus.m_addr, 32'h100);
        chk("lone_halt", 32'(bus.halt), 32'd0);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("lone_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("lone_i_rdata", bus.i_rdata, 32'h0000_0013);
        tick();
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("cont_d_gnt", 32'(bus.d_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
            chk("cont_halt", 32'(bus.halt), 32'd1);
            tick();
        end
        bus.i_req = 1'b0;
        bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_be = 4'b0101; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_m_write", 32'(bus.m_write), 32'd1);
        chk("st_m_be", 32'(bus.m_be), 32'b0101);
        chk("st_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.d_we = 1'b0;
        @(negedge clk);
        chk("st_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("ld_d_gnt", 32'(bus.d_gnt), 32'd1);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("ld_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("ld_d_rdata", bus.d_rdata, 32'h00AD_00EF);
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000_0004;
        @(negedge clk);
        chk("io_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("io_m_write", 32'(bus.m_write), 32'd0);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        chk("io_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        tick();
        bus.i_req = 1'b1;
        @(negedge clk);
        chk("rr_i_gnt", 32'(bus.i_gnt), 32'd1);
        tick();
        bus.i_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rr_drop1", 32'(bus.i_rvalid), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rr_drop2", 32'(bus.i_rvalid), 32'd0);
        chk("rr_i_rdata_clr", bus.i_rdata, 32'd0);
        tick();
        bus.i_req = 1'b1;
        @(negedge clk);
        chk("post_i_gnt", 32'(bus.i_gnt), 32'd1);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("post_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("post_i_rdata", bus.i_rdata, 32'h0000_0013);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
